// File: rtl/main_wrap.sv
// Single-cycle RV32I-subset core with a built-in self-check program ROM and a 64-word data RAM.
// Every instruction fetches, executes and commits its PC, register and memory updates on one rising edge.
module main_wrap (
  input  logic clk,
  input  logic rst
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;
  localparam logic [3:0] ALU_SLL = 4'd6;
  localparam logic [3:0] ALU_SRL = 4'd7;

  // Probe-visible nets keep their legacy names so existing benches can reach them.
  logic [31:0] pc_add;
  logic [31:0] instruct;
  logic [31:0] alu_result;
  logic [31:0] Readdata;
  logic [31:0] write_data;
  logic        RegWrite;
  logic        Branch;

  logic [31:0] r_regs [0:31];
  logic [31:0] r_ram  [0:63];

  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [6:0]  w_funct7;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_b;
  logic [31:0] w_imm;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_alu_b;
  logic [3:0]  w_alu_op;
  logic        w_alu_src_imm;
  logic        w_use_s_imm;
  logic        w_mem_write;
  logic        w_mem_to_reg;
  logic        w_beq_ok;
  logic        w_take;
  logic [31:0] w_pc_next;

  always_comb begin
    instruct = 32'h0000_0013;
    case (pc_add[7:2])
      6'd0:    instruct = 32'h0050_0093;
      6'd1:    instruct = 32'h0030_0113;
      6'd2:    instruct = 32'h0020_81B3;
      6'd3:    instruct = 32'h0030_2023;
      6'd4:    instruct = 32'h0000_2203;
      6'd5:    instruct = 32'h4012_02B3;
      6'd6:    instruct = 32'h0022_8463;
      6'd7:    instruct = 32'h0010_0313;
      6'd8:    instruct = 32'h0000_0063;
      default: instruct = 32'h0000_0013;
    endcase
  end

  assign w_opcode = instruct[6:0];
  assign w_rd     = instruct[11:7];
  assign w_funct3 = instruct[14:12];
  assign w_rs1    = instruct[19:15];
  assign w_rs2    = instruct[24:20];
  assign w_funct7 = instruct[31:25];

  assign w_imm_i = {{20{instruct[31]}}, instruct[31:20]};
  assign w_imm_s = {{20{instruct[31]}}, instruct[31:25], instruct[11:7]};
  assign w_imm_b = {{19{instruct[31]}}, instruct[31], instruct[7], instruct[30:25],
                    instruct[11:8], 1'b0};
  assign w_imm   = w_use_s_imm ? w_imm_s : w_imm_i;

  // Unrecognised opcode/funct combinations leave every write enable low, so they behave as a nop.
  always_comb begin
    RegWrite      = 1'b0;
    Branch        = 1'b0;
    w_beq_ok      = 1'b0;
    w_mem_write   = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_alu_src_imm = 1'b0;
    w_use_s_imm   = 1'b0;
    w_alu_op      = ALU_ADD;
    case (w_opcode)
      OP_R: begin
        RegWrite = 1'b1;
        case ({w_funct7, w_funct3})
          {7'h00, 3'b000}: w_alu_op = ALU_ADD;
          {7'h20, 3'b000}: w_alu_op = ALU_SUB;
          {7'h00, 3'b111}: w_alu_op = ALU_AND;
          {7'h00, 3'b110}: w_alu_op = ALU_OR;
          {7'h00, 3'b100}: w_alu_op = ALU_XOR;
          {7'h00, 3'b010}: w_alu_op = ALU_SLT;
          {7'h00, 3'b001}: w_alu_op = ALU_SLL;
          {7'h00, 3'b101}: w_alu_op = ALU_SRL;
          default:         RegWrite = 1'b0;
        endcase
      end
      OP_I: begin
        w_alu_src_imm = 1'b1;
        RegWrite      = 1'b1;
        case (w_funct3)
          3'b000:  w_alu_op = ALU_ADD;
          3'b111:  w_alu_op = ALU_AND;
          3'b110:  w_alu_op = ALU_OR;
          3'b100:  w_alu_op = ALU_XOR;
          3'b010:  w_alu_op = ALU_SLT;
          default: RegWrite = 1'b0;
        endcase
      end
      OP_LOAD: begin
        w_alu_src_imm = 1'b1;
        if (w_funct3 == 3'b010) begin
          RegWrite     = 1'b1;
          w_mem_to_reg = 1'b1;
        end
      end
      OP_STORE: begin
        w_alu_src_imm = 1'b1;
        w_use_s_imm   = 1'b1;
        w_mem_write   = (w_funct3 == 3'b010);
      end
      OP_BRANCH: begin
        Branch   = 1'b1;
        w_alu_op = ALU_SUB;
        w_beq_ok = (w_funct3 == 3'b000);
      end
      default: ;
    endcase
  end

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];
  assign w_alu_b   = w_alu_src_imm ? w_imm : w_rs2_val;

  always_comb begin
    alu_result = 32'd0;
    case (w_alu_op)
      ALU_ADD: alu_result = w_rs1_val + w_alu_b;
      ALU_SUB: alu_result = w_rs1_val - w_alu_b;
      ALU_AND: alu_result = w_rs1_val & w_alu_b;
      ALU_OR:  alu_result = w_rs1_val | w_alu_b;
      ALU_XOR: alu_result = w_rs1_val ^ w_alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
      ALU_SLL: alu_result = w_rs1_val << w_alu_b[4:0];
      ALU_SRL: alu_result = w_rs1_val >> w_alu_b[4:0];
      default: alu_result = 32'd0;
    endcase
  end

  assign Readdata   = r_ram[alu_result[7:2]];
  assign write_data = w_mem_to_reg ? Readdata : alu_result;

  assign w_take    = Branch && w_beq_ok && (w_rs1_val == w_rs2_val);
  assign w_pc_next = w_take ? (pc_add + w_imm_b) : (pc_add + 32'd4);

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_add <= 32'd0;
    end else begin
      pc_add <= w_pc_next;
    end
  end

  // x0 is held at zero by the write guard; reads of x0 are also forced to zero above.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (RegWrite && (w_rd != 5'd0)) begin
      r_regs[w_rd] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        r_ram[i] <= 32'd0;
      end
    end else if (w_mem_write) begin
      r_ram[alu_result[7:2]] <= w_rs2_val;
    end
  end

endmodule

// File: tb/tb_main_wrap.sv
// Directed bench for main_wrap: runs the ROM self-check program, checks the halt loop,
// then resets mid-run and checks that the program repeats from PC 0.
module tb_main_wrap;

  logic clk;
  logic rst;

  int n_vec  = 0;
  int n_fail = 0;

  // Hand-derived per-cycle expectations for the ROM program, cycle k = k-th instruction after reset.
  logic [31:0] exp_pc    [0:7] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h20};
  logic [31:0] exp_ins   [0:7] = '{32'h00500093, 32'h00300113, 32'h002081B3, 32'h00302023,
                                   32'h00002203, 32'h401202B3, 32'h00228463, 32'h00000063};
  logic [31:0] exp_alu   [0:7] = '{32'd5, 32'd3, 32'd8, 32'd0, 32'd0, 32'd3, 32'd0, 32'd0};
  logic [31:0] exp_wd    [0:7] = '{32'd5, 32'd3, 32'd8, 32'd0, 32'd8, 32'd3, 32'd0, 32'd0};
  logic [31:0] exp_rd    [0:7] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd8, 32'd8, 32'd8, 32'd8};
  logic        exp_rw    [0:7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        exp_br    [0:7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] exp_regs  [1:6] = '{32'd5, 32'd3, 32'd8, 32'd8, 32'd3, 32'd0};

  main_wrap dut (
    .clk (clk),
    .rst (rst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_cycle(input int k);
    check($sformatf("c%0d_pc", k),    dut.pc_add,     exp_pc[k]);
    check($sformatf("c%0d_ins", k),   dut.instruct,   exp_ins[k]);
    check($sformatf("c%0d_alu", k),   dut.alu_result, exp_alu[k]);
    check($sformatf("c%0d_wd", k),    dut.write_data, exp_wd[k]);
    check($sformatf("c%0d_rdata", k), dut.Readdata,   exp_rd[k]);
    check($sformatf("c%0d_rw", k),    {31'd0, dut.RegWrite}, {31'd0, exp_rw[k]});
    check($sformatf("c%0d_br", k),    {31'd0, dut.Branch},   {31'd0, exp_br[k]});
  endtask

  task automatic check_regs_after_program;
    for (int r = 1; r <= 6; r++) begin
      check($sformatf("x%0d", r), dut.r_regs[r], exp_regs[r]);
    end
    check("x0_zero", dut.r_regs[0], 32'd0);
    check("ram0", dut.r_ram[0], 32'd8);
  endtask

  task automatic check_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step();
      check($sformatf("halt%0d_pc", i),  dut.pc_add,   32'h20);
      check($sformatf("halt%0d_ins", i), dut.instruct, 32'h00000063);
      check($sformatf("halt%0d_br", i),  {31'd0, dut.Branch},   32'd1);
      check($sformatf("halt%0d_rw", i),  {31'd0, dut.RegWrite}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < 32; r++) begin
      check($sformatf("rst_x%0d", r), dut.r_regs[r], 32'd0);
    end
    check("rst_ram0", dut.r_ram[0], 32'd0);
    rst = 1'b0;

    // First pass: cycles 0..7, then registers, memory and halt loop.
    check_cycle(0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check_cycle(k);
    end
    check_regs_after_program();
    check_halt(6);

    // Second pass: reset asserted during cycle 4, program must restart identically.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_cycle(0);
    for (int k = 1; k <= 4; k++) begin
      step();
      check_cycle(k);
    end
    rst = 1'b1;
    step();
    check("mid_pc", dut.pc_add, 32'd0);
    for (int r = 1; r <= 5; r++) begin
      check($sformatf("mid_x%0d", r), dut.r_regs[r], 32'd0);
    end
    check("mid_ram0", dut.r_ram[0], 32'd0);
    rst = 1'b0;
    check_cycle(0);
    for (int k = 1; k <= 7; k++) begin
      step();
      check_cycle(k);
    end
    check_regs_after_program();
    check_halt(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/main_wrap.md
# main_wrap

Single-cycle RV32I-subset processor top level, the `sequential` flavour of the team's RISC-V core. It contains:

- the program counter;
- a built-in instruction ROM holding a fixed self-check program;
- a 32×32 register file, immediate generator, main and ALU control, and ALU;
- a data RAM and the write-back mux.

Every instruction completes in one clock. The core has no external buses; benches observe it through mandatory named internal nets.

## Interface
- Parameters: none. Memories are fixed at 64 words each: byte address bits [7:2] index them, upper bits are ignored.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- Required internal nets at the top scope, for hierarchical probing:
  - `pc_add` [31:0]: current PC.
  - `instruct` [31:0]: fetched instruction.
  - `alu_result` [31:0]: ALU output.
  - `Readdata` [31:0]: data RAM read.
  - `write_data` [31:0]: register write-back value.
  - `RegWrite`: register-file write enable.
  - `Branch`: branch-instruction flag.

## Operation
- Fetch: `instruct` = ROM[`pc_add`[7:2]], combinational.
- ROM contents, by byte address:
  - 00: 0x00500093, addi x1,x0,5
  - 04: 0x00300113, addi x2,x0,3
  - 08: 0x002081B3, add x3,x1,x2
  - 0C: 0x00302023, sw x3,0(x0)
  - 10: 0x00002203, lw x4,0(x0)
  - 14: 0x401202B3, sub x5,x4,x1
  - 18: 0x00228463, beq x5,x2,+8
  - 1C: 0x00100313, addi x6,x0,1
  - 20: 0x00000063, beq x0,x0,0 (halt loop)
  - all other words: 0x00000013 (nop)
- Supported opcodes:
  - R 0110011: add, sub (funct7[5]=1), and, or, xor, slt, sll, srl.
  - I 0010011: addi, andi, ori, xori, slti.
  - load 0000011: lw.
  - store 0100011: sw.
  - branch 1100011: beq.
- Unsupported opcode or funct: no register or memory write, PC+4.
- Immediates are sign-extended:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
- ALU operands: A = rs1; B = rs2 for R-type and beq, immediate otherwise.
- All arithmetic is 32-bit wrap-around; slt is signed; shift amount is B[4:0].
- `RegWrite` = 1 for R, I-ALU and lw.
- `write_data` = `Readdata` for lw, else `alu_result`.
- Writes to x0 are discarded; reading x0 always returns 0.
- Register reads are combinational. If rd = rs, the read returns the old value.
- Data RAM:
  - read is combinational: `Readdata` = RAM[`alu_result`[7:2]];
  - write happens on the rising edge when sw.
- `Branch` = 1 for opcode 1100011.
- Next PC:
  - `pc_add` + B-imm when `Branch` and (rs1 == rs2);
  - otherwise `pc_add` + 4;
  - wraps modulo 2^32.

## Timing
- One instruction per cycle. The PC, the register write and the RAM write all commit on the same rising edge.
- Rising edge with `rst`=1:
  - `pc_add` ← 0;
  - all registers ← 0;
  - all RAM words ← 0;
  - no instruction commits that cycle.
- `rst` asserted mid-program: takes effect at the next edge; the program restarts from 0 the following cycle.
- Before the first reset, state is undefined. Benches must reset for ≥1 edge.
- After reset release, instruction k executes during cycle k. PC reaches 0x20 at cycle 7 (0x1C is skipped) and holds there indefinitely.
- Outputs settle combinationally within the cycle.

## Test plan
- Reset: hold `rst` for 2 edges → `pc_add`=0, `instruct`=0x00500093, `alu_result`=5, `RegWrite`=1.
- ALU and register file:
  - cycle 2 (PC 08): `alu_result`=8 and `write_data`=8;
  - cycle 5 (PC 14): `alu_result`=3, since sub = 8−5.
- Memory:
  - cycle 3 (PC 0C): `RegWrite`=0 and `alu_result`=0;
  - cycle 4 (PC 10): `Readdata`=8 and `write_data`=8.
- Branch: cycle 6 (PC 18) has `Branch`=1; the next PC is 0x20, not 0x1C, and x6 stays 0.
- Halt: from cycle 7 onward, `pc_add`=0x20, `instruct`=0x00000063, `Branch`=1, `RegWrite`=0, for ≥5 cycles.
- Mid-run reset: assert `rst` at cycle 4 → next cycle `pc_add`=0, x1–x5=0, RAM[0]=0, and the sequence repeats identically.
